debug_ring_mesh_chain: RTL
==========================

# debug_ring_mesh_chain

- Parametrised debug-ring interconnect for an X×Y tile array.
- Connects the debug interface and all X*Y compute tiles into one ring in serpentine (meander) order, replacing per-system hand-written ring assigns.
- Registers every hop with a 2-entry skid buffer per channel, so long ring wires are timing-closed at full throughput.
- Sits in the system top between `debug_interface` and the `compute_tile_dm` instances.

## Interface

Parameters:

- `X`, default 3: tiles per mesh row.
- `Y`, default 3: mesh rows; NODES = X*Y, HOPS = NODES+1.
- `CHANNELS`, default 2: debug ring channels per link.

Ports (flit type `dii_flit` = {valid, last, data[15:0]}):

- `clk` input 1: single clock for the whole block.
- `rst` input 1: synchronous, active-high reset.
- `if_ring_out` input `dii_flit[CHANNELS-1:0]`: flits from the debug interface into the ring.
- `if_ring_out_ready` output `[CHANNELS-1:0]`: ready toward the debug interface.
- `if_ring_in` output `dii_flit[CHANNELS-1:0]`: flits returning to the debug interface.
- `if_ring_in_ready` input `[CHANNELS-1:0]`: debug interface accepts returning flits.
- `tile_ring_out` input `dii_flit[CHANNELS-1:0] [0:NODES-1]`: flits from each tile, indexed by tile ID.
- `tile_ring_out_ready` output `[CHANNELS-1:0] [0:NODES-1]`: ready toward each tile's ring output.
- `tile_ring_in` output `dii_flit[CHANNELS-1:0] [0:NODES-1]`: flits into each tile.
- `tile_ring_in_ready` input `[CHANNELS-1:0] [0:NODES-1]`: tile accepts flits.

## Operation

- Ring position p (0..NODES-1) maps to tile T(p):
  - r = p / X, c = p % X.
  - T = r*X + c for even r; T = r*X + (X-1-c) for odd r.
- Hop 0 runs from the interface to T(0).
- Hop k (1..NODES-1) runs from T(k-1) to T(k).
- Hop NODES runs from T(NODES-1) back to the interface.
- Each hop and channel has one independent skid buffer (2-entry FIFO):
  - Push when upstream `valid && ready`.
  - Pop when downstream `valid && ready`.
  - Output valid = count != 0; output flit = head entry with valid forced to 1.
  - Upstream ready = count != 2 and not `rst`.
- Push and pop in the same cycle: count unchanged, FIFO order kept. This is legal at count 1, and pop-only at count 2.
- `last` and `data` pass through unmodified. The block never reorders, drops or merges flits, and channels never interact.
- Reset:
  - All buffers empty.
  - Every ring output has valid=0, last=0, data=0.
  - Every ready output is 0 while `rst`=1 and 1 in the first cycle after `rst` falls.
  - Flits held at reset are discarded.

## Timing

- Latency: a flit accepted at edge n is presented downstream after edge n, and may be consumed at edge n+1.
- Latency from interface to T(k) is k+1 cycles. Full ring traversal with no stalls takes HOPS cycles.
- Throughput is 1 flit/cycle/channel/hop under continuous ready.
- All outputs are registered. There is no combinational path from any ready input to any ready output.
- Backpressure: a downstream stall stops upstream acceptance after at most 2 flits are buffered, at the edge where count reaches 2.

## Configuration

- Macro `DEBUG_RING_HOP_STATS_EN`.
- Defined: the block adds the following ports:
  - `stat_hop` input [$clog2(HOPS)-1:0].
  - `stat_ch` input [$clog2(CHANNELS)-1:0]; width is 1 when CHANNELS = 1.
  - `stat_clear` input 1.
  - `stat_count` output 32.
- Counter behaviour:
  - Each hop/channel has a 32-bit counter that increments on every push and wraps 0xFFFFFFFF→0.
  - `stat_count` registers the selected counter one cycle after selection.
  - `stat_clear` zeroes all counters at the next edge and has priority over an increment in that cycle.
  - Reset zeroes all counters and `stat_count`.
  - Out-of-range `stat_hop` or `stat_ch` reads 0.
- Undefined: none of these ports or counters exist, and ring behaviour is identical.

## Test plan

- **Mapping:** X=3, Y=3, CHANNELS=2. Inject data=0x0101, last=1 on channel 0 from the interface with all tiles echoing. The flit visits tiles 0,1,2,5,4,3,6,7,8, then returns to the interface exactly 10 cycles after acceptance.
- **Throughput:** 64 back-to-back flits with data 0..63 on channel 1, all ready=1. All 64 arrive in order with no gaps; channel 0 outputs stay valid=0.
- **Backpressure:** hold `tile_ring_in_ready` of tile 0 at 0 while streaming. Exactly 2 flits buffer at hop 0 and `if_ring_out_ready` drops to 0. Release: flits 0,1,2… resume in order with none lost or duplicated.
- **Reset mid-stream:** assert `rst` for 1 cycle with every buffer full. All valid outputs are 0 and all readys are 0 during reset, and all readys are 1 the cycle after.
- **Degenerate mesh:** X=1, Y=1. Ring is interface→tile 0→interface with 2-cycle round trip; `last` is preserved on a 3-flit packet.
- **Stats (macro defined):** send 5 flits on hop 0 channel 0 with stat_hop=0, stat_ch=0. `stat_count`=5. Pulse `stat_clear` → 0. Preload to 0xFFFFFFFF and push 1 flit → 0.

Source files
------------

// File: rtl/debug_ring_mesh_chain.sv
// debug_ring_mesh_chain: links the debug interface and the X*Y compute tiles
// into a single debug ring in serpentine order. Row 0 runs left to right,
// row 1 right to left, and so on. Every hop and channel is registered through
// a 2-entry skid buffer, so ready never has a combinational path across a hop.
//
// Flit layout on every port: bit 17 = valid, bit 16 = last, bits 15:0 = data.
//
// Optional feature macro: DEBUG_RING_HOP_STATS_EN
//   When defined, every hop/channel gets a 32-bit push counter. stat_hop and
//   stat_ch select one counter, which is registered onto stat_count.
module debug_ring_mesh_chain #(
    parameter int X        = 3,
    parameter int Y        = 3,
    parameter int CHANNELS = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
`ifdef DEBUG_RING_HOP_STATS_EN
    input  logic [$clog2(X*Y+1)-1:0]                stat_hop,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] stat_ch,
    input  logic                                    stat_clear,
    output logic [31:0]                             stat_count,
`endif
    input  logic [CHANNELS-1:0][17:0]               if_ring_out,
    output logic [CHANNELS-1:0]                     if_ring_out_ready,
    output logic [CHANNELS-1:0][17:0]               if_ring_in,
    input  logic [CHANNELS-1:0]                     if_ring_in_ready,
    input  logic [CHANNELS-1:0][0:X*Y-1][17:0]      tile_ring_out,
    output logic [CHANNELS-1:0][0:X*Y-1]            tile_ring_out_ready,
    output logic [CHANNELS-1:0][0:X*Y-1][17:0]      tile_ring_in,
    input  logic [CHANNELS-1:0][0:X*Y-1]            tile_ring_in_ready
);

    localparam int NODES = X * Y;
    localparam int HOPS  = NODES + 1;

    // Tile ID at ring position p: odd rows are walked right to left.
    function automatic int tile_of(input int p);
        int r;
        int c;
        r = p / X;
        c = p % X;
        if ((r % 2) == 0) return r * X + c;
        else              return r * X + (X - 1 - c);
    endfunction

`ifdef DEBUG_RING_HOP_STATS_EN
    logic [31:0] stat_arr [HOPS*CHANNELS];
    logic [31:0] stat_sel;
    logic [31:0] stat_count_q;
`endif

    for (genvar k = 0; k < HOPS; k++) begin : g_hop
        // Tile feeding this hop (unused for hop 0) and tile it drives (unused for the last hop).
        localparam int T_UP = (k == 0) ? 0 : tile_of(k - 1);
        localparam int T_DN = (k == NODES) ? 0 : tile_of(k);

        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [17:0] in_flit;
            logic [17:0] out_flit;
            logic        in_rdy;
            logic        out_rdy;
            logic        push;
            logic        pop;
            logic [1:0]  cnt_q, cnt_d;
            logic [16:0] head_q, head_d;
            logic [16:0] tail_q, tail_d;

            // Upstream side of the hop: interface for hop 0, previous tile otherwise.
            if (k == 0) begin : g_src_if
                assign in_flit               = if_ring_out[ch];
                assign if_ring_out_ready[ch] = in_rdy;
            end else begin : g_src_tile
                assign in_flit                        = tile_ring_out[ch][T_UP];
                assign tile_ring_out_ready[ch][T_UP]  = in_rdy;
            end

            // Downstream side of the hop: interface for the last hop, next tile otherwise.
            if (k == NODES) begin : g_dst_if
                assign if_ring_in[ch] = out_flit;
                assign out_rdy        = if_ring_in_ready[ch];
            end else begin : g_dst_tile
                assign tile_ring_in[ch][T_DN] = out_flit;
                assign out_rdy                = tile_ring_in_ready[ch][T_DN];
            end

            // Handshake: a flit moves whenever valid and ready are both high at an edge.
            // Ready and valid are forced low while rst is high so nothing moves in reset.
            assign in_rdy   = (cnt_q != 2'd2) && !rst;
            assign push     = in_flit[17] && in_rdy;
            assign out_flit = ((cnt_q != 2'd0) && !rst) ? {1'b1, head_q} : 18'd0;
            assign pop      = out_flit[17] && out_rdy;

            // Next-state of the 2-entry FIFO; head is the oldest entry.
            always_comb begin
                cnt_d  = cnt_q;
                head_d = head_q;
                tail_d = tail_q;
                case ({push, pop})
                    2'b10: begin
                        if (cnt_q == 2'd0) head_d = in_flit[16:0];
                        else               tail_d = in_flit[16:0];
                        cnt_d = cnt_q + 2'd1;
                    end
                    2'b01: begin
                        head_d = tail_q;
                        cnt_d  = cnt_q - 2'd1;
                    end
                    2'b11: begin
                        // Only reachable at count 1: the new flit replaces the departing head.
                        head_d = in_flit[16:0];
                    end
                    default: ;
                endcase
            end

            // FIFO state register; reset empties the buffer and drops held flits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= 2'd0;
                    head_q <= 17'd0;
                    tail_q <= 17'd0;
                end else begin
                    cnt_q  <= cnt_d;
                    head_q <= head_d;
                    tail_q <= tail_d;
                end
            end

`ifdef DEBUG_RING_HOP_STATS_EN
            logic [31:0] pushes_q;

            // Push counter; clear wins over an increment in the same cycle.
            always_ff @(posedge clk) begin
                if (rst || stat_clear) pushes_q <= 32'd0;
                else if (push)         pushes_q <= pushes_q + 32'd1;
            end

            assign stat_arr[k*CHANNELS+ch] = pushes_q;
`endif
        end
    end

`ifdef DEBUG_RING_HOP_STATS_EN
    // Counter select; any out-of-range hop or channel reads as zero.
    always_comb begin
        stat_sel = 32'd0;
        for (int h = 0; h < HOPS; h++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(stat_hop) == h && int'(stat_ch) == c) stat_sel = stat_arr[h*CHANNELS+c];
            end
        end
    end

    // Register the selected counter one cycle after selection.
    always_ff @(posedge clk) begin
        if (rst) stat_count_q <= 32'd0;
        else     stat_count_q <= stat_sel;
    end

    assign stat_count = stat_count_q;
`endif

endmodule
